id_stage: RTL and testbench



---
 rtl/id_stage_if.sv | 49 ++++
 rtl/id_stage.sv | 154 +++++++++++++++
 tb/tb_id_stage.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_if.sv
// Decode-stage bundle: pipeline control, IF/ID instruction, writeback port,
// EX load-use info, and the operand/squash/stall outputs toward ID/EX and fetch.
interface id_stage_if;
    logic        load_latch;
    logic [15:0] IR_in;
    logic        wb_load_regfile;
    logic [2:0]  wb_dest;
    logic [15:0] wb_data;
    logic        ex_mem_read;
    logic [2:0]  ex_dest;
    logic        br_resolved;
    logic [15:0] SR1_out;
    logic [15:0] SR2_out;
    logic        squash_instruction;
    logic        stall_fetch;
    logic        state_wait;

    modport slave (
        input  load_latch,
        input  IR_in,
        input  wb_load_regfile,
        input  wb_dest,
        input  wb_data,
        input  ex_mem_read,
        input  ex_dest,
        input  br_resolved,
        output SR1_out,
        output SR2_out,
        output squash_instruction,
        output stall_fetch,
        output state_wait
    );

    modport master (
        output load_latch,
        output IR_in,
        output wb_load_regfile,
        output wb_dest,
        output wb_data,
        output ex_mem_read,
        output ex_dest,
        output br_resolved,
        input  SR1_out,
        input  SR2_out,
        input  squash_instruction,
        input  stall_fetch,
        input  state_wait
    );
endinterface

// File: rtl/id_stage.sv
// LC-3b decode stage: 8x16 register file with write-through bypass, load-use
// interlock, and the RUN/WAIT control-flow squash machine.
module id_stage (
    input  logic       clk,
    input  logic       reset,
    id_stage_if.slave  io
);
    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LDB  = 4'b0010;
    localparam logic [3:0] OP_STB  = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_SHF  = 4'b1101;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic [3:0]  opcode;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic        is_store;
    logic        uses_sr1;
    logic        uses_sr2;
    logic        is_cf;
    logic        hazard;
    logic        squash_next;
    logic        stall_next;
    logic        wait_next;

    logic [15:0] regs_reg [8];
    logic [2:0]  rd_addr  [2];
    logic [15:0] rd_data  [2];

    // Bits [4:3] carry no decode information for any source field.
    logic unused_ir_bits;
    assign unused_ir_bits = ^io.IR_in[4:3];

    always_comb begin
        opcode   = io.IR_in[15:12];
        sr1      = io.IR_in[8:6];
        is_store = (opcode == OP_STR) || (opcode == OP_STB) || (opcode == OP_STI);
        sr2      = is_store ? io.IR_in[11:9] : io.IR_in[2:0];

        uses_sr1 = 1'b0;
        case (opcode)
            OP_ADD, OP_AND, OP_NOT, OP_LDR, OP_LDB, OP_LDI,
            OP_STR, OP_STB, OP_STI, OP_JMP, OP_SHF: uses_sr1 = 1'b1;
            OP_JSR:                                  uses_sr1 = ~io.IR_in[11];
            default:                                 uses_sr1 = 1'b0;
        endcase

        uses_sr2 = (((opcode == OP_ADD) || (opcode == OP_AND)) && !io.IR_in[5]) || is_store;

        is_cf = ((opcode == OP_BR) && (io.IR_in[11:9] != 3'b000))
              || (opcode == OP_JMP) || (opcode == OP_JSR)
              || (opcode == OP_TRAP) || (opcode == OP_RTI);

        hazard = io.ex_mem_read
               && ((uses_sr1 && (io.ex_dest == sr1)) || (uses_sr2 && (io.ex_dest == sr2)));
    end

    // Writeback lands regardless of load_latch so a frozen pipe never loses a result.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_reg
            always_ff @(posedge clk) begin
                if (reset) begin
                    regs_reg[gi] <= 16'h0000;
                end else if (io.wb_load_regfile && (io.wb_dest == 3'(gi))) begin
                    regs_reg[gi] <= io.wb_data;
                end
            end
        end
    endgenerate

    assign rd_addr[0] = sr1;
    assign rd_addr[1] = sr2;

    // Reads in reset show zero so the cleared state is visible before the first edge.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            always_comb begin
                if (io.wb_load_regfile && (io.wb_dest == rd_addr[gi])) begin
                    rd_data[gi] = io.wb_data;
                end else if (reset) begin
                    rd_data[gi] = 16'h0000;
                end else begin
                    rd_data[gi] = regs_reg[rd_addr[gi]];
                end
            end
        end
    endgenerate

    assign io.SR1_out = rd_data[0];
    assign io.SR2_out = rd_data[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // A hazard blocks CF acceptance; the CF instruction retries after the bubble.
    always_comb begin
        state_next  = state_reg;
        squash_next = 1'b0;
        stall_next  = 1'b0;
        wait_next   = 1'b0;
        case (state_reg)
            RUN: begin
                squash_next = hazard;
                stall_next  = hazard;
                if (io.load_latch && is_cf && !hazard) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                squash_next = 1'b1;
                stall_next  = ~io.br_resolved;
                wait_next   = 1'b1;
                if (io.load_latch && io.br_resolved) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
        if (reset) begin
            squash_next = 1'b1;
            stall_next  = 1'b0;
            wait_next   = 1'b0;
        end
    end

    assign io.squash_instruction = squash_next;
    assign io.stall_fetch        = stall_next;
    assign io.state_wait         = wait_next;
endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed sequences, a vector table, and a
// randomized run against an opcode-set based behavioural model.
module tb_id_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_stage_if bus ();

    id_stage u_dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_txn = 0;

    // Model state: architectural registers and "a CF instruction is in flight".
    logic [15:0] m_regs [8];
    bit          m_cf_pending;

    // Opcode membership sets, bit index = opcode.
    logic [15:0] set_uses_sr1;
    logic [15:0] set_store;
    logic [15:0] set_cf;

    typedef struct {
        logic [15:0] ir;
        logic        wbl;
        logic [2:0]  wbd;
        logic [15:0] wbv;
        logic        exr;
        logic [2:0]  exd;
        logic [15:0] e1;
        logic [15:0] e2;
        logic        esq;
        logic        est;
    } vec_t;

    vec_t tbl [14];

    function automatic logic [2:0] m_src1(logic [15:0] ir);
        return ir[8:6];
    endfunction

    function automatic logic [2:0] m_src2(logic [15:0] ir);
        return set_store[ir[15:12]] ? ir[11:9] : ir[2:0];
    endfunction

    function automatic bit m_hazard(logic [15:0] ir, logic exr, logic [2:0] exd);
        bit u1;
        bit u2;
        u1 = set_uses_sr1[ir[15:12]] || (ir[15:12] == 4'd4 && !ir[11]);
        u2 = set_store[ir[15:12]] || ((ir[15:12] == 4'd1 || ir[15:12] == 4'd5) && !ir[5]);
        return exr && ((u1 && exd == m_src1(ir)) || (u2 && exd == m_src2(ir)));
    endfunction

    function automatic bit m_is_cf(logic [15:0] ir);
        return set_cf[ir[15:12]] || (ir[15:12] == 4'd0 && ir[11:9] != 3'd0);
    endfunction

    function automatic logic [15:0] m_read(logic [2:0] a);
        if (bus.wb_load_regfile && bus.wb_dest == a) return bus.wb_data;
        if (reset) return 16'h0000;
        return m_regs[a];
    endfunction

    task automatic cmp(string name, logic [15:0] act, logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(logic [15:0] ir, logic ll, logic wbl, logic [2:0] wbd,
                          logic [15:0] wbv, logic exr, logic [2:0] exd, logic brr);
        bus.IR_in           = ir;
        bus.load_latch      = ll;
        bus.wb_load_regfile = wbl;
        bus.wb_dest         = wbd;
        bus.wb_data         = wbv;
        bus.ex_mem_read     = exr;
        bus.ex_dest         = exd;
        bus.br_resolved     = brr;
    endtask

    task automatic model_update();
        if (reset) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
            m_cf_pending = 1'b0;
        end else begin
            if (bus.wb_load_regfile) m_regs[bus.wb_dest] = bus.wb_data;
            if (bus.load_latch) begin
                if (m_cf_pending) begin
                    if (bus.br_resolved) m_cf_pending = 1'b0;
                end else if (m_is_cf(bus.IR_in) && !m_hazard(bus.IR_in, bus.ex_mem_read, bus.ex_dest)) begin
                    m_cf_pending = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic chk_exp(string tag, logic [15:0] e1, logic [15:0] e2,
                           logic esq, logic est, logic ew);
        @(negedge clk);
        n_txn++;
        $display("txn %0d %s ir=%h sr1=%h sr2=%h sq=%b st=%b w=%b", n_txn, tag,
                 bus.IR_in, bus.SR1_out, bus.SR2_out,
                 bus.squash_instruction, bus.stall_fetch, bus.state_wait);
        cmp({tag, ".sr1"},   bus.SR1_out, e1);
        cmp({tag, ".sr2"},   bus.SR2_out, e2);
        cmp({tag, ".squash"}, 16'(bus.squash_instruction), 16'(esq));
        cmp({tag, ".stall"},  16'(bus.stall_fetch), 16'(est));
        cmp({tag, ".wait"},   16'(bus.state_wait), 16'(ew));
    endtask

    task automatic chk_model(string tag);
        logic esq;
        logic est;
        logic ew;
        bit   hz;
        hz = m_hazard(bus.IR_in, bus.ex_mem_read, bus.ex_dest);
        if (reset) begin
            esq = 1'b1; est = 1'b0; ew = 1'b0;
        end else if (m_cf_pending) begin
            esq = 1'b1; est = ~bus.br_resolved; ew = 1'b1;
        end else begin
            esq = hz; est = hz; ew = 1'b0;
        end
        chk_exp(tag, m_read(m_src1(bus.IR_in)), m_read(m_src2(bus.IR_in)), esq, est, ew);
    endtask

    initial begin
        set_uses_sr1 = 16'h3EEE;
        set_store    = 16'h0888;
        set_cf       = 16'h9110;
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        m_cf_pending = 1'b0;

        tbl[0]  = '{16'h1642, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h1111, 16'h2222, 1'b0, 1'b0};
        tbl[1]  = '{16'h7241, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 16'h1111, 16'h1111, 1'b1, 1'b1};
        tbl[2]  = '{16'h1065, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 16'h1111, 16'h5555, 1'b0, 1'b0};
        tbl[3]  = '{16'h1065, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 16'h1111, 16'h5555, 1'b0, 1'b0};
        tbl[4]  = '{16'h1045, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 16'h1111, 16'h5555, 1'b1, 1'b1};
        tbl[5]  = '{16'h95BF, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 16'h6666, 16'h7777, 1'b1, 1'b1};
        tbl[6]  = '{16'hE3C5, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd7, 16'h7777, 16'h5555, 1'b0, 1'b0};
        tbl[7]  = '{16'h4801, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 16'h0000, 16'h1111, 1'b0, 1'b0};
        tbl[8]  = '{16'h40C0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 16'h3333, 16'h0000, 1'b1, 1'b1};
        tbl[9]  = '{16'h1883, 1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 16'h2222, 16'hBEEF, 1'b0, 1'b0};
        tbl[10] = '{16'h3AC0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 16'hBEEF, 16'h5555, 1'b1, 1'b1};
        tbl[11] = '{16'h60C0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 16'hBEEF, 16'h0000, 1'b0, 1'b0};
        tbl[12] = '{16'h1000, 1'b1, 3'd0, 16'h1234, 1'b0, 3'd0, 16'h1234, 16'h1234, 1'b0, 1'b0};
        tbl[13] = '{16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 16'h1234, 16'h1234, 1'b0, 1'b0};

        // Reset and first decode after release.
        reset = 1'b1;
        set_in(16'h1042, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0);
        chk_exp("in_reset", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        chk_exp("post_reset_add", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick();

        // Writeback bypass, then the same value from storage.
        set_in(16'h1641, 1'b1, 1'b1, 3'd1, 16'hBEEF, 1'b0, 3'd0, 1'b0);
        chk_exp("wb_bypass", 16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(16'h1641, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0);
        chk_exp("wb_stored", 16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        tick();

        // BR nzp=111 accepted, three wait cycles, then resolution.
        set_in(16'h0E05, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0);
        chk_exp("br_accept", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(16'h1042, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk_exp("br_wait", 16'hBEEF, 16'h0000, 1'b1, 1'b1, 1'b1);
            tick();
        end
        bus.br_resolved = 1'b1;
        chk_exp("br_resolve", 16'hBEEF, 16'h0000, 1'b1, 1'b0, 1'b1);
        tick();
        bus.br_resolved = 1'b0;
        chk_exp("br_back_run", 16'hBEEF, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick();

        // JMP R2 with a load-use hazard on R2: bubble first, WAIT afterwards.
        set_in(16'hC080, 1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 1'b0);
        chk_exp("jmp_hazard", 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0);
        tick();
        bus.ex_mem_read = 1'b0;
        chk_exp("jmp_retry", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(16'h1042, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0);
        chk_exp("jmp_wait", 16'hBEEF, 16'h0000, 1'b1, 1'b1, 1'b1);
        tick();

        // Frozen pipe in WAIT: state held, R7 write still lands.
        set_in(16'h11C7, 1'b0, 1'b1, 3'd7, 16'h7E7E, 1'b0, 3'd0, 1'b0);
        chk_exp("frozen_wb", 16'h7E7E, 16'h7E7E, 1'b1, 1'b1, 1'b1);
        tick();
        bus.wb_load_regfile = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_exp("frozen_hold", 16'h7E7E, 16'h7E7E, 1'b1, 1'b1, 1'b1);
            tick();
        end

        // Reset from WAIT.
        reset = 1'b1;
        bus.load_latch = 1'b1;
        chk_exp("reset_in_wait", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        chk_exp("after_wait_reset_r7", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick();
        bus.IR_in = 16'h1042;
        chk_exp("after_wait_reset_r1", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick();

        // Preload Rk = 0x1111*k, then table vectors with the pipe frozen.
        for (int k = 0; k < 8; k++) begin
            set_in(16'h0000, 1'b1, 1'b1, 3'(k), 16'(16'h1111 * k), 1'b0, 3'd0, 1'b0);
            tick();
        end
        for (int i = 0; i < 14; i++) begin
            set_in(tbl[i].ir, 1'b0, tbl[i].wbl, tbl[i].wbd, tbl[i].wbv,
                   tbl[i].exr, tbl[i].exd, 1'b0);
            chk_exp($sformatf("vec%0d", i), tbl[i].e1, tbl[i].e2, tbl[i].esq, tbl[i].est, 1'b0);
            tick();
        end

        // Randomized run against the model.
        reset = 1'b1;
        set_in(16'h0000, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            set_in(16'($urandom), ($urandom_range(0, 9) < 8), 1'($urandom),
                   3'($urandom), 16'($urandom), ($urandom_range(0, 9) < 4),
                   3'($urandom), ($urandom_range(0, 3) == 0));
            chk_model("rand");
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
